// File: rtl/bnn_pkg.sv
// Shared definitions for the binarized-network datapath blocks.
//   sumw(n)  : bit width of a popcount sum ranging 0..n
//   idxw(m)  : bit width of an index over m items (minimum 1)
//   state_e  : sequential argmax FSM states
package bnn_pkg;

  function automatic int unsigned sumw(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  function automatic int unsigned idxw(input int unsigned m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_argmax.sv
// Sequential argmax over M popcount sums, one neuron per cycle.
// Optional runner-up tracking and margin output: define SEQ_ARGMAX_MARGIN_EN.
// Ports:
//   clk, rst (async, active-low)
//   in_valid/in_ready/sums        : input vector handshake, neuron k at sums[k*SUML +: SUML]
//   out_valid/out_ready           : result handshake
//   out_class, out_max            : winning index and its sum (lowest index wins ties)
//   out_margin (optional)         : best minus second-best sum
module seq_argmax
  import bnn_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned M = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [M*sumw(N)-1:0]      sums,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [idxw(M)-1:0]        out_class,
`ifdef SEQ_ARGMAX_MARGIN_EN
  output logic [sumw(N)-1:0]        out_margin,
`endif
  output logic [sumw(N)-1:0]        out_max
);

  localparam int unsigned SUML = sumw(N);
  localparam int unsigned IDXW = idxw(M);
  localparam int unsigned VECW = M * SUML;

  state_e            state_q, state_d;
  logic [VECW-1:0]   snap_q, snap_d;
  logic [SUML-1:0]   best_q, best_d;
  logic [IDXW-1:0]   cls_q, cls_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [SUML-1:0]   cand;
`ifdef SEQ_ARGMAX_MARGIN_EN
  logic [SUML-1:0]   second_q, second_d;
  logic [SUML-1:0]   margin_q, margin_d;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      snap_q   <= '0;
      best_q   <= '0;
      cls_q    <= '0;
      idx_q    <= '0;
`ifdef SEQ_ARGMAX_MARGIN_EN
      second_q <= '0;
      margin_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      snap_q   <= snap_d;
      best_q   <= best_d;
      cls_q    <= cls_d;
      idx_q    <= idx_d;
`ifdef SEQ_ARGMAX_MARGIN_EN
      second_q <= second_d;
      margin_q <= margin_d;
`endif
    end
  end

  // Neuron under examination, taken from the snapshot so upstream changes are ignored
  assign cand = snap_q[idx_q*SUML +: SUML];

  // Next-state and compare/update
  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    best_d   = best_q;
    cls_d    = cls_q;
    idx_d    = idx_q;
`ifdef SEQ_ARGMAX_MARGIN_EN
    second_d = second_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          snap_d   = sums;
          best_d   = sums[SUML-1:0];
          cls_d    = '0;
          idx_d    = IDXW'(1);
`ifdef SEQ_ARGMAX_MARGIN_EN
          second_d = '0;
`endif
          state_d  = (M > 1) ? SCAN : DONE;
        end
      end
      SCAN: begin
        // Strict compare keeps the lowest index on ties
        if (cand > best_q) begin
          best_d   = cand;
          cls_d    = idx_q;
`ifdef SEQ_ARGMAX_MARGIN_EN
          second_d = best_q;
        end else if (cand > second_q) begin
          second_d = cand;
`endif
        end
        idx_d = idx_q + IDXW'(1);
        if (idx_q == IDXW'(M - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SEQ_ARGMAX_MARGIN_EN
  // Margin registered alongside best/second so it is stable with out_max
  assign margin_d   = best_d - second_d;
  assign out_margin = margin_q;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_class = cls_q;
  assign out_max   = best_q;

endmodule

// File: tb/tb_seq_argmax.sv
// Self-checking bench for seq_argmax: directed cases, random vectors against a
// behavioural argmax model, backpressure, and reset during a scan.
// Define SEQ_ARGMAX_MARGIN_EN to also check out_margin.
module tb_seq_argmax;

  localparam int unsigned N    = 4;
  localparam int unsigned M    = 4;
  localparam int unsigned SUML = $clog2(N + 1);
  localparam int unsigned IDXW = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned SW   = M * SUML;
  localparam int          BUDGET = 50;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [SW-1:0]   sums;
  logic            out_valid;
  logic            out_ready;
  logic [IDXW-1:0] out_class;
  logic [SUML-1:0] out_max;
`ifdef SEQ_ARGMAX_MARGIN_EN
  logic [SUML-1:0] out_margin;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    int cls;
    int mx;
    int margin;
  } res_t;

  always #5 clk = ~clk;

  seq_argmax #(.N(N), .M(M)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sums      (sums),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
`ifdef SEQ_ARGMAX_MARGIN_EN
    .out_margin(out_margin),
`endif
    .out_max   (out_max)
  );

  // Reference: max value, first index holding it, max minus best of the rest
  function automatic res_t ref_argmax(input logic [SW-1:0] s);
    res_t r;
    int   vals[M];
    int   sec;
    for (int k = 0; k < M; k++) vals[k] = int'((s >> (k * SUML)) & ((1 << SUML) - 1));
    r.mx = -1;
    r.cls = 0;
    for (int k = 0; k < M; k++) begin
      if (vals[k] > r.mx) begin
        r.mx  = vals[k];
        r.cls = k;
      end
    end
    sec = 0;
    for (int k = 0; k < M; k++) begin
      if (k != r.cls && vals[k] > sec) sec = vals[k];
    end
    r.margin = r.mx - sec;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a vector and wait for it to be taken; leaves time at accept edge + 1
  task automatic accept(input logic [SW-1:0] s, input string name);
    int n = 0;
    while (!in_ready && n < BUDGET) begin
      tick();
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL %s accept: in_ready=%0b required 1 within %0d cycles", name, in_ready, BUDGET);
    end
    in_valid = 1'b1;
    sums     = s;
    tick();
    in_valid = 1'b0;
    sums     = SW'($urandom);
  endtask

  // Wait for the result, check latency and values, then release it
  task automatic collect(input logic [SW-1:0] s, input string name);
    res_t exp = ref_argmax(s);
    int   lat = 0;
    while (!out_valid && lat < BUDGET) begin
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s busy_in_ready: got %0b required 0", name, in_ready);
      end
      tick();
      lat++;
    end
    checks++;
    if (lat !== M - 1) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles required %0d", name, lat, M - 1);
    end
    checks++;
    if (out_class !== IDXW'(exp.cls)) begin
      errors++;
      $display("FAIL %s out_class: got %0d required %0d (sums=%h)", name, out_class, exp.cls, s);
    end
    checks++;
    if (out_max !== SUML'(exp.mx)) begin
      errors++;
      $display("FAIL %s out_max: got %0d required %0d (sums=%h)", name, out_max, exp.mx, s);
    end
`ifdef SEQ_ARGMAX_MARGIN_EN
    checks++;
    if (out_margin !== SUML'(exp.margin)) begin
      errors++;
      $display("FAIL %s out_margin: got %0d required %0d (sums=%h)", name, out_margin, exp.margin, s);
    end
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s release: in_ready=%0b out_valid=%0b required 1/0", name, in_ready, out_valid);
    end
  endtask

  task automatic run_vec(input logic [SW-1:0] s, input string name);
    accept(s, name);
    collect(s, name);
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sums      = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset in_ready: got %0b required 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset out_valid: got %0b required 0", out_valid);
    end
    checks++;
    if (out_class !== '0) begin
      errors++;
      $display("FAIL reset out_class: got %0d required 0", out_class);
    end
    checks++;
    if (out_max !== '0) begin
      errors++;
      $display("FAIL reset out_max: got %0d required 0", out_max);
    end
  endtask

  task automatic test_directed();
    run_vec(12'h313, "basic");     // n3=1 n2=4 n1=2 n0=3
    run_vec(12'h8A0, "tie");       // n3=4 n2=2 n1=4 n0=0
    run_vec(12'h000, "zeros");
    run_vec(12'hFFF, "all_max");   // out-of-range 7s, tie everywhere
    run_vec(12'h007, "first_big"); // only n0 nonzero
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++) begin
      logic [SW-1:0] s;
      s = SW'($urandom);
      run_vec(s, "random");
    end
  endtask

  task automatic test_backpressure();
    logic [SW-1:0] first = 12'h313;
    logic [SW-1:0] nxt   = 12'h8A0;
    res_t          exp   = ref_argmax(first);
    int            lat   = 0;
    accept(first, "bp");
    while (!out_valid && lat < BUDGET) begin
      tick();
      lat++;
    end
    in_valid = 1'b1;
    sums     = nxt;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_valid !== 1'b1 || out_class !== IDXW'(exp.cls) || out_max !== SUML'(exp.mx) ||
          in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: valid=%0b class=%0d max=%0d in_ready=%0b required 1/%0d/%0d/0",
                 c, out_valid, out_class, out_max, in_ready, exp.cls, exp.mx);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
    end
    tick();
    in_valid = 1'b0;
    sums     = SW'($urandom);
    collect(nxt, "bp_next");
  endtask

  task automatic test_reset_mid_scan();
    accept(12'h8A0, "rst_scan");
    tick();
    rst = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_class !== '0 || out_max !== '0) begin
      errors++;
      $display("FAIL rst_scan async: valid=%0b in_ready=%0b class=%0d max=%0d required 0/1/0/0",
               out_valid, in_ready, out_class, out_max);
    end
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL rst_scan idle cycle %0d: valid=%0b in_ready=%0b required 0/1", c, out_valid, in_ready);
      end
    end
    run_vec(12'h313, "after_rst");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_scan();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
